// File: rtl/sll_iter_if.sv
// Start/done handshake bundle for the iterative left shifter.
// The master drives the request; the slave (shifter) returns status and the result.
interface sll_iter_if #(
  parameter int N = 16
);
  localparam int K = $clog2(N);

  logic         start;
  logic [K-1:0] shift_amount;
  logic [N-1:0] dataIn;
  logic         busy;
  logic         done;
  logic [N-1:0] dataOut;

  modport master (
    output start, shift_amount, dataIn,
    input  busy, done, dataOut
  );

  modport slave (
    input  start, shift_amount, dataIn,
    output busy, done, dataOut
  );
endinterface

// File: rtl/sll_iter.sv
// Iterative logical left shifter: one barrel stage (shift by 1<<stage) per clock.
// Optional `define SLL_ITER_EARLY_EXIT_EN finishes once no higher amount bits remain.
module sll_iter #(
  parameter int N = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  sll_iter_if.slave  bus_io
);
  localparam int K = $clog2(N);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t       state_q;
  logic [N-1:0] work_q;
  logic [K-1:0] amt_q;
  logic [K-1:0] stage_q;
  logic [N-1:0] dataout_q;

  logic [N-1:0] shifted [K];
  logic [N-1:0] stage_shift;
  logic         stage_apply;
  logic [N-1:0] work_d;
  logic         last_stage;

  genvar gi;
  generate
    for (gi = 0; gi < K; gi++) begin : g_stage
      assign shifted[gi] = work_q << (1 << gi);
    end
  endgenerate

  always_comb begin
    stage_shift = work_q;
    stage_apply = 1'b0;
    for (int i = 0; i < K; i++) begin
      if (int'(stage_q) == i) begin
        stage_shift = shifted[i];
        stage_apply = amt_q[i];
      end
    end
    work_d = stage_apply ? stage_shift : work_q;
  end

`ifdef SLL_ITER_EARLY_EXIT_EN
  logic [K:0] stage_plus1;
  assign stage_plus1 = {1'b0, stage_q} + {{K{1'b0}}, 1'b1};
  // Done once every remaining amount bit above this stage is zero.
  assign last_stage  = ((amt_q >> stage_plus1) == '0);
`else
  localparam logic [K-1:0] LAST_STAGE = K[K-1:0] - {{(K-1){1'b0}}, 1'b1};
  assign last_stage = (stage_q == LAST_STAGE);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      work_q    <= '0;
      amt_q     <= '0;
      stage_q   <= '0;
      dataout_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          // A start in DONE is accepted so back-to-back ops take K+1 cycles.
          if (bus_io.start) begin
            work_q  <= bus_io.dataIn;
            amt_q   <= bus_io.shift_amount;
            stage_q <= '0;
            state_q <= SHIFT;
          end else begin
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          work_q  <= work_d;
          stage_q <= stage_q + {{(K-1){1'b0}}, 1'b1};
          if (last_stage) begin
            dataout_q <= work_d;
            state_q   <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus_io.busy    = (state_q == SHIFT);
  assign bus_io.done    = (state_q == DONE);
  assign bus_io.dataOut = dataout_q;
endmodule
